xif_commit_tracker: RTL and testbench



---
 rtl/coprosit_tracker_pkg.sv | 25 ++
 rtl/xif_id_match.sv | 33 +++
 rtl/xif_commit_tracker.sv | 150 +++++++++++++++
 tb/tb_xif_commit_tracker.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coprosit_tracker_pkg.sv
// Shared types for the XIF commit tracker: per-entry state, entry payload, default sizes.
// Latency: n/a (types only); backpressure: n/a.
package coprosit_tracker_pkg;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READY  = 2'd2,
    ST_KILLED = 2'd3
  } entry_state_e;

  localparam int unsigned TRK_DEPTH  = 4;
  localparam int unsigned TRK_ID_W   = 4;
  localparam int unsigned TRK_NUM_RS = 2;
  localparam int unsigned TRK_RFR_W  = 32;
  localparam int unsigned TRK_CNT_W  = $clog2(TRK_DEPTH) + 1;

  // Payload layout follows the TRK_* sizes; the tracker's parameters default to them.
  typedef struct packed {
    logic [31:0]                      instr;
    logic [TRK_ID_W-1:0]              id;
    logic [TRK_NUM_RS*TRK_RFR_W-1:0]  rs;
  } trk_entry_t;

endpackage

// File: rtl/xif_id_match.sv
// Oldest-first id CAM over WAIT entries, scanning from the head pointer; one-hot result.
// Latency: combinational; backpressure: none.
module xif_id_match
  import coprosit_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  entry_state_e                 state_i [DEPTH],
  input  logic [DEPTH-1:0][ID_W-1:0]   id_i,
  input  logic [PTR_W-1:0]             head_i,
  input  logic [ID_W-1:0]              match_id_i,
  output logic [DEPTH-1:0]             match_oh_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    match_oh_o = '0;
    found      = 1'b0;
    idx        = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (!found && (state_i[idx] == ST_WAIT) && (id_i[idx] == match_id_i)) begin
        match_oh_o[idx] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xif_commit_tracker.sv
// In-order speculation buffer between XIF issue/commit and the execute pipe; optional kill counter via COPROSIT_TRACKER_PERF_EN.
// Latency: push+commit in cycle N gives ex_valid_o in N+1; backpressure: in_ready_o drops at DEPTH entries, ex_* held while ex_ready_i=0.
module xif_commit_tracker
  import coprosit_tracker_pkg::*;
#(
  parameter int unsigned DEPTH       = TRK_DEPTH,
  parameter int unsigned X_ID_WIDTH  = TRK_ID_W,
  parameter int unsigned X_NUM_RS    = TRK_NUM_RS,
  parameter int unsigned X_RFR_WIDTH = TRK_RFR_W
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [31:0]                     in_instr_i,
  input  logic [X_ID_WIDTH-1:0]           in_id_i,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] in_rs_i,
  input  logic                            commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]           commit_id_i,
  input  logic                            commit_kill_i,
  output logic                            ex_valid_o,
  input  logic                            ex_ready_i,
  output logic [31:0]                     ex_instr_o,
  output logic [X_ID_WIDTH-1:0]           ex_id_o,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] ex_rs_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic                            busy_o
`ifdef COPROSIT_TRACKER_PERF_EN
  ,
  input  logic                            kill_cnt_clr_i,
  output logic [15:0]                     kill_cnt_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_state_e state_q [DEPTH];
  entry_state_e state_d [DEPTH];
  trk_entry_t   entry_q [DEPTH];
  trk_entry_t   entry_d [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0][X_ID_WIDTH-1:0] entry_ids;
  logic [DEPTH-1:0]                 match_oh;
  entry_state_e                     head_state;
  entry_state_e                     commit_state;
  logic push, pop, drain, leave, new_hit;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ids
    assign entry_ids[g] = entry_q[g].id;
  end

  xif_id_match #(
    .DEPTH (DEPTH),
    .ID_W  (X_ID_WIDTH)
  ) u_id_match (
    .state_i    (state_q),
    .id_i       (entry_ids),
    .head_i     (head_q),
    .match_id_i (commit_id_i),
    .match_oh_o (match_oh)
  );

  assign in_ready_o   = (count_q < CNT_W'(DEPTH));
  assign push         = in_valid_i & in_ready_o;
  assign head_state   = state_q[head_q];
  assign ex_valid_o   = (head_state == ST_READY);
  assign pop          = ex_valid_o & ex_ready_i;
  assign drain        = (head_state == ST_KILLED);
  assign leave        = pop | drain;
  assign commit_state = commit_kill_i ? ST_KILLED : ST_READY;
  // A same-cycle commit lands on the incoming entry only if no older WAIT entry claims the id.
  assign new_hit      = commit_valid_i & ~(|match_oh) & (commit_id_i == in_id_i);

  assign ex_instr_o = entry_q[head_q].instr;
  assign ex_id_o    = entry_q[head_q].id;
  assign ex_rs_o    = entry_q[head_q].rs;
  assign count_o    = count_q;
  assign busy_o     = (count_q != '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      entry_d[i] = entry_q[i];
      if (commit_valid_i && match_oh[i]) begin
        state_d[i] = commit_state;
      end
    end
    if (leave) begin
      state_d[head_q] = ST_FREE;
    end
    if (push) begin
      state_d[tail_q]       = new_hit ? commit_state : ST_WAIT;
      entry_d[tail_q].instr = in_instr_i;
      entry_d[tail_q].id    = in_id_i;
      entry_d[tail_q].rs    = in_rs_i;
    end
    head_d  = leave ? head_q + PTR_W'(1) : head_q;
    tail_d  = push  ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(leave);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        entry_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        entry_q[i] <= entry_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef COPROSIT_TRACKER_PERF_EN
  logic [15:0] kill_cnt_q, kill_cnt_d;

  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (kill_cnt_clr_i) begin
      kill_cnt_d = '0;
    end else if (drain && (kill_cnt_q != 16'hFFFF)) begin
      kill_cnt_d = kill_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kill_cnt_q <= '0;
    end else begin
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign kill_cnt_o = kill_cnt_q;
`endif

endmodule

// File: tb/tb_xif_commit_tracker.sv
// Directed bench for xif_commit_tracker: push/commit/kill ordering, full, wrap, async reset.
module tb_xif_commit_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_id;
  logic [63:0] in_rs;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_instr;
  logic [3:0]  ex_id;
  logic [63:0] ex_rs;
  logic [2:0]  count;
  logic        busy;
`ifdef COPROSIT_TRACKER_PERF_EN
  logic        kill_cnt_clr;
  logic [15:0] kill_cnt;
`endif

  always #5 clk = ~clk;

  xif_commit_tracker dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_instr_i     (in_instr),
    .in_id_i        (in_id),
    .in_rs_i        (in_rs),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .ex_valid_o     (ex_valid),
    .ex_ready_i     (ex_ready),
    .ex_instr_o     (ex_instr),
    .ex_id_o        (ex_id),
    .ex_rs_o        (ex_rs),
    .count_o        (count),
    .busy_o         (busy)
`ifdef COPROSIT_TRACKER_PERF_EN
    ,
    .kill_cnt_clr_i (kill_cnt_clr),
    .kill_cnt_o     (kill_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int disp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every dispatch handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) disp_q.push_back(int'(ex_id));
  end

  function automatic logic [31:0] instr_of(input logic [3:0] id);
    return 32'hC0DE_0000 | {28'd0, id};
  endfunction

  function automatic logic [63:0] rs_of(input logic [3:0] id);
    return {32'hB000_0000 | {28'd0, id}, 32'hA000_0000 | {28'd0, id}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [3:0] id);
    in_valid = 1'b1;
    in_id    = id;
    in_instr = instr_of(id);
    in_rs    = rs_of(id);
  endtask

  task automatic drive_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic check_disp(input string tag, input int n, input int a, input int b);
    chk({tag, "_n"}, 64'(disp_q.size()), 64'(n));
    if (disp_q.size() == n) begin
      if (n > 0) chk({tag, "_0"}, 64'(disp_q[0]), 64'(a));
      if (n > 1) chk({tag, "_1"}, 64'(disp_q[1]), 64'(b));
    end
    disp_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_instr = '0;
    in_id    = '0;
    in_rs    = '0;
    commit_id = '0;
    ex_ready = 1'b0;
    idle_inputs();
`ifdef COPROSIT_TRACKER_PERF_EN
    kill_cnt_clr = 1'b0;
`endif
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_id", 64'(ex_id), 64'd0);
    chk("rst_ex_instr", 64'(ex_instr), 64'd0);
    chk("rst_ex_rs", ex_rs, 64'd0);
`ifdef COPROSIT_TRACKER_PERF_EN
    chk("rst_kill_cnt", 64'(kill_cnt), 64'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // Single push, commit two cycles later, dispatch.
    drive_push(4'd3);
    step();
    idle_inputs();
    chk("t1_count_after_push", 64'(count), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_no_valid_wait", 64'(ex_valid), 64'd0);
    step();
    drive_commit(4'd3, 1'b0);
    ex_ready = 1'b1;
    chk("t1_no_valid_commit_cycle", 64'(ex_valid), 64'd0);
    step();
    idle_inputs();
    chk("t1_valid", 64'(ex_valid), 64'd1);
    chk("t1_ex_id", 64'(ex_id), 64'd3);
    chk("t1_ex_instr", 64'(ex_instr), 64'(instr_of(4'd3)));
    chk("t1_ex_rs", ex_rs, rs_of(4'd3));
    step();
    chk("t1_count_after_pop", 64'(count), 64'd0);
    chk("t1_valid_after_pop", 64'(ex_valid), 64'd0);
    check_disp("t1_disp", 1, 3, 0);

    // Fill to DEPTH (pointers wrap), reject push when full, then free one slot.
    ex_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_push(4'(i));
      step();
    end
    drive_push(4'd15);
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_in_ready", 64'(in_ready), 64'd0);
    step();
    idle_inputs();
    chk("t2_no_push_when_full", 64'(count), 64'd4);
    drive_commit(4'd1, 1'b0);
    ex_ready = 1'b1;
    step();
    idle_inputs();
    chk("t2_valid_id1", 64'(ex_valid), 64'd1);
    chk("t2_ex_id1", 64'(ex_id), 64'd1);
    chk("t2_in_ready_pop_cycle", 64'(in_ready), 64'd0);
    step();
    chk("t2_in_ready_after_pop", 64'(in_ready), 64'd1);
    chk("t2_count_after_pop", 64'(count), 64'd3);
    chk("t2_head_wait_no_valid", 64'(ex_valid), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      drive_commit(4'(i), 1'b1);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    chk("t2_drained_count", 64'(count), 64'd0);
    check_disp("t2_disp", 1, 1, 0);

    // Kill one, commit the next.
`ifdef COPROSIT_TRACKER_PERF_EN
    chk("t2_kill_cnt", 64'(kill_cnt), 64'd3);
    kill_cnt_clr = 1'b1;
    step();
    kill_cnt_clr = 1'b0;
    chk("t3_kill_cnt_clr", 64'(kill_cnt), 64'd0);
`endif
    drive_push(4'd5);
    step();
    drive_push(4'd6);
    step();
    idle_inputs();
    drive_commit(4'd5, 1'b1);
    step();
    chk("t3_killed_head_no_valid", 64'(ex_valid), 64'd0);
    drive_commit(4'd6, 1'b0);
    step();
    idle_inputs();
    chk("t3_valid_id6", 64'(ex_valid), 64'd1);
    chk("t3_ex_id6", 64'(ex_id), 64'd6);
    step();
    step();
    chk("t3_count", 64'(count), 64'd0);
    check_disp("t3_disp", 1, 6, 0);
`ifdef COPROSIT_TRACKER_PERF_EN
    chk("t3_kill_cnt", 64'(kill_cnt), 64'd1);
`endif

    // Younger committed entry waits behind an uncommitted head.
    drive_push(4'd7);
    step();
    drive_push(4'd8);
    step();
    idle_inputs();
    drive_commit(4'd8, 1'b0);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("t4_blocked_no_valid", 64'(ex_valid), 64'd0);
      step();
    end
    chk("t4_blocked_count", 64'(count), 64'd2);
    drive_commit(4'd7, 1'b0);
    step();
    idle_inputs();
    chk("t4_valid_id7", 64'(ex_valid), 64'd1);
    chk("t4_ex_id7", 64'(ex_id), 64'd7);
    step();
    chk("t4_valid_id8", 64'(ex_valid), 64'd1);
    chk("t4_ex_id8", 64'(ex_id), 64'd8);
    step();
    chk("t4_empty_valid", 64'(ex_valid), 64'd0);
    chk("t4_empty_count", 64'(count), 64'd0);
    check_disp("t4_disp", 2, 7, 8);

    // Same-cycle push and commit, held under backpressure.
    ex_ready = 1'b0;
    drive_push(4'd9);
    drive_commit(4'd9, 1'b0);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_valid", 64'(ex_valid), 64'd1);
      chk("t5_hold_id", 64'(ex_id), 64'd9);
      chk("t5_hold_instr", 64'(ex_instr), 64'(instr_of(4'd9)));
      chk("t5_hold_rs", ex_rs, rs_of(4'd9));
      if (i < 2) step();
    end
    ex_ready = 1'b1;
    step();
    chk("t5_after_pop_valid", 64'(ex_valid), 64'd0);
    chk("t5_after_pop_count", 64'(count), 64'd0);
    check_disp("t5_disp", 1, 9, 0);

    // Asynchronous reset with entries held, one of them ready at the head.
    ex_ready = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      drive_push(4'(i));
      step();
    end
    idle_inputs();
    drive_commit(4'd10, 1'b0);
    step();
    idle_inputs();
    chk("t6_pre_rst_count", 64'(count), 64'd3);
    chk("t6_pre_rst_valid", 64'(ex_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_valid", 64'(ex_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    disp_q.delete();
    step();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_stale_valid", 64'(ex_valid), 64'd0);
    end
    check_disp("t6_disp", 0, 0, 0);
`ifdef COPROSIT_TRACKER_PERF_EN
    chk("t6_kill_cnt", 64'(kill_cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
